// File: rtl/ad9253_pkg.sv
// Shared constants for the AD9253 IDELAYE3 load path: tap/counter widths and
// the loader FSM state encoding.
package ad9253_pkg;

    localparam int TAP_W      = 9;
    localparam int LOAD_CNT_W = 16;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_VTC_OFF = 3'd1;
    localparam logic [2:0] ST_LOAD    = 3'd2;
    localparam logic [2:0] ST_SETTLE  = 3'd3;
    localparam logic [2:0] ST_CHECK   = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

endpackage

// File: rtl/ad9253_idelay_loader_satcnt.sv
// Saturating event counter: increments on inc_i and sticks at all-ones.
module ad9253_idelay_loader_satcnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ad9253_idelay_loader.sv
// Per-lane IDELAYE3 VAR_LOAD sequencer: drops EN_VTC, loads the requested tap,
// verifies it through CNTVALUEOUT with bounded retries, then restores EN_VTC.
module ad9253_idelay_loader
    import ad9253_pkg::*;
#(
    parameter int VTC_WAIT  = 10,
    parameter int SETTLE    = 8,
    parameter int MAX_RETRY = 3,
    parameter int MAX_TAP   = 511
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [TAP_W-1:0]      tap_target,
    input  logic                  en_vtc_req,
    input  logic [TAP_W-1:0]      dly_cntvalueout,
    output logic                  dly_load,
    output logic [TAP_W-1:0]      dly_cntvaluein,
    output logic                  dly_en_vtc,
    output logic [TAP_W-1:0]      cur_tap,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_err,
    output logic [LOAD_CNT_W-1:0] load_cnt
);

    localparam int VTC_CW = (VTC_WAIT < 1) ? 1 : $clog2(VTC_WAIT + 1);
    localparam int SET_CW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
    localparam int RTY_CW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    function automatic logic [TAP_W-1:0] clamp_tap(input logic [TAP_W-1:0] t);
        if (int'(t) > MAX_TAP) begin
            return TAP_W'(MAX_TAP);
        end
        return t;
    endfunction

    function automatic logic [VTC_CW-1:0] vtc_sat_inc(input logic [VTC_CW-1:0] c);
        if (c == VTC_CW'(VTC_WAIT)) begin
            return c;
        end
        return c + VTC_CW'(1);
    endfunction

    logic [2:0]        state_q,   state_d;
    logic [TAP_W-1:0]  lat_tgt_q, lat_tgt_d;
    logic [TAP_W-1:0]  applied_q, applied_d;
    logic [TAP_W-1:0]  cur_tap_q, cur_tap_d;
    logic [RTY_CW-1:0] retry_q,   retry_d;
    logic [SET_CW-1:0] settle_q,  settle_d;
    logic [VTC_CW-1:0] vtc_cnt_q, vtc_cnt_d;
    logic              en_vtc_q,  en_vtc_d;
    logic              err_q,     err_d;
    logic [TAP_W-1:0]  tgt_c;

    assign tgt_c = clamp_tap(tap_target);

    always_comb begin
        state_d   = state_q;
        lat_tgt_d = lat_tgt_q;
        applied_d = applied_q;
        cur_tap_d = cur_tap_q;
        retry_d   = retry_q;
        settle_d  = settle_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (tgt_c != applied_q) begin
                    lat_tgt_d = tgt_c;
                    retry_d   = '0;
                    state_d   = ST_VTC_OFF;
                end
            end
            ST_VTC_OFF: begin
                if (vtc_cnt_q == VTC_CW'(VTC_WAIT)) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                settle_d = '0;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == SET_CW'(SETTLE - 1)) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q + SET_CW'(1);
                end
            end
            ST_CHECK: begin
                if (dly_cntvalueout == lat_tgt_q) begin
                    cur_tap_d = lat_tgt_q;
                    applied_d = lat_tgt_q;
                    state_d   = ST_DONE;
                end else if (retry_q != RTY_CW'(MAX_RETRY)) begin
                    // EN_VTC stays low across retries, so go straight back to LOAD.
                    retry_d = retry_q + RTY_CW'(1);
                    state_d = ST_LOAD;
                end else begin
                    // Mark the target applied anyway so a stuck lane cannot retry forever.
                    err_d     = 1'b1;
                    cur_tap_d = dly_cntvalueout;
                    applied_d = lat_tgt_q;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // EN_VTC follows the request only while idle; the low-time counter
        // includes the current cycle so LOAD sees at least VTC_WAIT low cycles.
        en_vtc_d  = (state_d == ST_IDLE) ? en_vtc_req : 1'b0;
        vtc_cnt_d = en_vtc_d ? '0 : vtc_sat_inc(vtc_cnt_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            lat_tgt_q <= '0;
            applied_q <= '0;
            cur_tap_q <= '0;
            retry_q   <= '0;
            settle_q  <= '0;
            vtc_cnt_q <= VTC_CW'(VTC_WAIT);
            en_vtc_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_tgt_q <= lat_tgt_d;
            applied_q <= applied_d;
            cur_tap_q <= cur_tap_d;
            retry_q   <= retry_d;
            settle_q  <= settle_d;
            vtc_cnt_q <= vtc_cnt_d;
            en_vtc_q  <= en_vtc_d;
            err_q     <= err_d;
        end
    end

    assign dly_load       = (state_q == ST_LOAD);
    assign dly_cntvaluein = lat_tgt_q;
    assign dly_en_vtc     = en_vtc_q;
    assign cur_tap        = cur_tap_q;
    assign load_busy      = (state_q != ST_IDLE);
    assign load_done      = (state_q == ST_DONE);
    assign load_err       = err_q;

    ad9253_idelay_loader_satcnt #(
        .W(LOAD_CNT_W)
    ) u_load_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (load_done),
        .cnt_o (load_cnt)
    );

endmodule

// File: tb/tb_ad9253_idelay_loader.sv
// Directed bench for ad9253_idelay_loader with a behavioural IDELAYE3 readback model.
module tb_ad9253_idelay_loader;

    logic        clk;
    logic        rst_n;
    logic [8:0]  tap_target;
    logic        en_vtc_req;
    logic [8:0]  dly_cntvalueout;
    logic        dly_load;
    logic [8:0]  dly_cntvaluein;
    logic        dly_en_vtc;
    logic [8:0]  cur_tap;
    logic        load_busy;
    logic        load_done;
    logic        load_err;
    logic [15:0] load_cnt;

    logic [8:0]  model_tap;
    logic        bad;
    logic [8:0]  bad_val;

    int nvec  = 0;
    int nfail = 0;
    int exp_cnt;

    ad9253_idelay_loader dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tap_target      (tap_target),
        .en_vtc_req      (en_vtc_req),
        .dly_cntvalueout (dly_cntvalueout),
        .dly_load        (dly_load),
        .dly_cntvaluein  (dly_cntvaluein),
        .dly_en_vtc      (dly_en_vtc),
        .cur_tap         (cur_tap),
        .load_busy       (load_busy),
        .load_done       (load_done),
        .load_err        (load_err),
        .load_cnt        (load_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // IDELAYE3 model: LOAD captures CNTVALUEIN; a stuck lane reports bad_val.
    initial model_tap = '0;
    always @(posedge clk) begin
        if (dly_load) model_tap <= dly_cntvaluein;
    end
    assign dly_cntvalueout = bad ? bad_val : model_tap;

    typedef struct {
        logic [8:0] tgt;
        logic       en;
        logic       bad;
        logic [8:0] bad_val;
        int         exp_cur;
        int         exp_loads;
        int         exp_load_k;
        int         exp_done_k;
        int         exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Steps negedges after a stimulus change; k counts negedges since the change.
    task automatic run_seq(input int limit, output int fall_k, output int load_k,
                           output int done_k, output int nloads, output logic [8:0] load_val);
        fall_k = 0; load_k = 0; done_k = 0; nloads = 0; load_val = '0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (!dly_en_vtc && fall_k == 0) fall_k = k;
            if (dly_load) begin
                nloads++;
                if (load_k == 0) begin
                    load_k   = k;
                    load_val = dly_cntvaluein;
                end
            end
            if (load_done) begin
                done_k = k;
                break;
            end
        end
    endtask

    int          fk, lk, dk, nl;
    logic [8:0]  lv;
    int          d1, d2;
    int          cur13, busy13, busy14;

    initial begin
        rst_n = 1'b0; en_vtc_req = 1'b1; tap_target = '0; bad = 1'b0; bad_val = '0;
        exp_cnt = 0;

        // Reset state and idle behaviour with no target change
        idle_cycles(3);
        chk("rst_dly_en_vtc", dly_en_vtc, 0);
        chk("rst_dly_load",   dly_load,   0);
        chk("rst_busy",       load_busy,  0);
        chk("rst_done",       load_done,  0);
        chk("rst_err",        load_err,   0);
        chk("rst_load_cnt",   load_cnt,   0);
        chk("rst_cur_tap",    cur_tap,    0);
        chk("rst_cntvaluein", dly_cntvaluein, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_en_vtc_2nd_cycle", dly_en_vtc, 1);
        run_seq(20, fk, lk, dk, nl, lv);
        chk("t1_no_load",  nl, 0);
        chk("t1_no_done",  dk, 0);
        chk("t1_load_cnt", load_cnt, 0);
        chk("t1_en_vtc",   dly_en_vtc, 1);

        // VTC high: full VTC_WAIT before LOAD
        tap_target = 9'd120;
        run_seq(60, fk, lk, dk, nl, lv);
        chk("t2_vtc_fall_k", fk, 1);
        chk("t2_load_k",     lk, 11);
        chk("t2_load_val",   lv, 120);
        chk("t2_loads",      nl, 1);
        chk("t2_done_k",     dk, 21);
        @(negedge clk);
        exp_cnt = 1;
        chk("t2_cur_tap",  cur_tap, 120);
        chk("t2_load_cnt", load_cnt, exp_cnt);
        chk("t2_en_vtc",   dly_en_vtc, 1);
        chk("t2_busy",     load_busy, 0);

        // VTC already low long enough: best-case latency
        en_vtc_req = 1'b0;
        idle_cycles(15);
        tap_target = 9'd200;
        run_seq(60, fk, lk, dk, nl, lv);
        chk("t3_load_k", lk, 2);
        chk("t3_done_k", dk, 12);
        @(negedge clk);
        exp_cnt = 2;
        chk("t3_cur_tap",  cur_tap, 200);
        chk("t3_load_cnt", load_cnt, exp_cnt);

        // Stuck readback: 1 + MAX_RETRY loads, then sticky error
        bad = 1'b1; bad_val = 9'd249;
        tap_target = 9'd250;
        run_seq(100, fk, lk, dk, nl, lv);
        chk("t4_loads",  nl, 4);
        chk("t4_done_k", dk, 42);
        @(negedge clk);
        exp_cnt = 3;
        chk("t4_err",      load_err, 1);
        chk("t4_cur_tap",  cur_tap, 249);
        chk("t4_load_cnt", load_cnt, exp_cnt);
        run_seq(30, fk, lk, dk, nl, lv);
        chk("t4_no_reload", nl, 0);
        chk("t4_no_redone", dk, 0);

        vecs[0] = '{9'd300, 1'b0, 1'b0, 9'd0,  300, 1, 2,  12, 1};
        vecs[1] = '{9'd511, 1'b0, 1'b0, 9'd0,  511, 1, 2,  12, 1};
        vecs[2] = '{9'd0,   1'b0, 1'b0, 9'd0,  0,   1, 2,  12, 1};
        vecs[3] = '{9'd5,   1'b1, 1'b0, 9'd0,  5,   1, 11, 21, 1};
        vecs[4] = '{9'd5,   1'b1, 1'b0, 9'd0,  5,   0, 0,  0,  1};
        vecs[5] = '{9'd77,  1'b1, 1'b1, 9'd76, 76,  4, 11, 51, 1};
        vecs[6] = '{9'd77,  1'b0, 1'b0, 9'd0,  76,  0, 0,  0,  1};
        vecs[7] = '{9'd78,  1'b0, 1'b0, 9'd0,  78,  1, 2,  12, 1};

        for (int v = 0; v < 8; v++) begin
            en_vtc_req = vecs[v].en;
            bad        = vecs[v].bad;
            bad_val    = vecs[v].bad_val;
            idle_cycles(15);
            tap_target = vecs[v].tgt;
            run_seq((vecs[v].exp_done_k == 0) ? 30 : 80, fk, lk, dk, nl, lv);
            chk($sformatf("v%0d_loads", v),  nl, vecs[v].exp_loads);
            chk($sformatf("v%0d_load_k", v), lk, vecs[v].exp_load_k);
            chk($sformatf("v%0d_done_k", v), dk, vecs[v].exp_done_k);
            if (vecs[v].exp_loads != 0) chk($sformatf("v%0d_load_val", v), lv, vecs[v].tgt);
            @(negedge clk);
            if (vecs[v].exp_done_k != 0) exp_cnt++;
            chk($sformatf("v%0d_cur_tap", v),  cur_tap, vecs[v].exp_cur);
            chk($sformatf("v%0d_err", v),      load_err, vecs[v].exp_err);
            chk($sformatf("v%0d_load_cnt", v), load_cnt, exp_cnt);
            chk($sformatf("v%0d_busy", v),     load_busy, 0);
            chk($sformatf("v%0d_en_vtc", v),   dly_en_vtc, vecs[v].en);
        end

        // Target change during SETTLE: back-to-back sequences with one IDLE cycle
        en_vtc_req = 1'b0; bad = 1'b0;
        idle_cycles(15);
        tap_target = 9'd40;
        d1 = 0; d2 = 0; cur13 = -1; busy13 = -1; busy14 = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 5) tap_target = 9'd60;
            if (k == 13) begin cur13 = cur_tap; busy13 = load_busy; end
            if (k == 14) busy14 = load_busy;
            if (load_done) begin
                if (d1 == 0) d1 = k;
                else begin d2 = k; break; end
            end
        end
        chk("t5_done1_k", d1, 12);
        chk("t5_cur_after_first", cur13, 40);
        chk("t5_idle_gap", busy13, 0);
        chk("t5_restart",  busy14, 1);
        chk("t5_done2_k",  d2, 25);
        @(negedge clk);
        exp_cnt += 2;
        chk("t5_cur_tap",  cur_tap, 60);
        chk("t5_load_cnt", load_cnt, exp_cnt);

        // Asynchronous reset during LOAD
        tap_target = 9'd100;
        idle_cycles(2);
        chk("t6_in_load", dly_load, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_load_drop",   dly_load,   0);
        chk("t6_busy_drop",   load_busy,  0);
        chk("t6_en_vtc_drop", dly_en_vtc, 0);
        chk("t6_cur_tap",     cur_tap,    0);
        chk("t6_load_cnt",    load_cnt,   0);
        chk("t6_err_clear",   load_err,   0);
        tap_target = 9'd0; en_vtc_req = 1'b1;
        idle_cycles(2);
        rst_n = 1'b1;
        run_seq(10, fk, lk, dk, nl, lv);
        chk("t6_post_loads", nl, 0);
        chk("t6_post_busy",  load_busy, 0);
        chk("t6_post_cur",   cur_tap, 0);
        chk("t6_post_en_vtc", dly_en_vtc, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
